// File: rtl/sprite_line_renderer_pkg.sv
// Shared constants for the sprite line renderer: attribute byte layout,
// FSM state encoding and the sprite ROM address packing.
package sprite_line_renderer_pkg;

  localparam int unsigned NSPR  = 48;
  localparam int unsigned SPH   = 16;
  localparam int unsigned IDX_W = 6;

  // Attribute byte 1 bit positions
  localparam int unsigned B1_X8    = 7;
  localparam int unsigned B1_CODE8 = 6;
  localparam int unsigned B1_FLIPY = 5;
  localparam int unsigned B1_FLIPX = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_CHK,
    S_FETCH,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic logic [13:0] rom_addr(input logic [8:0] code,
                                           input logic [3:0] row,
                                           input logic       half);
    return {code, row, half};
  endfunction

endpackage

// File: rtl/sprite_line_renderer_pixel_shifter.sv
// Holds one 32-bit sprite ROM word and presents pixel k (or 7-k when flipped)
// together with its opaque flag.
module sprite_pixel_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        flip,
  input  logic [2:0]  sel,
  output logic [3:0]  pixel,
  output logic        opaque
);

  logic [31:0] word_r;
  logic [2:0]  slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
    end else if (load) begin
      word_r <= word;
    end
  end

  always_comb begin
    slot   = flip ? (3'd7 - sel) : sel;
    pixel  = word_r[{slot, 2'b00} +: 4];
    opaque = (pixel != 4'd0);
  end

endmodule

// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite renderer: scans attribute RAM, fetches rows of hit
// sprites from ROM and writes opaque pixels into the selected line-buffer half.
module sprite_line_renderer
  import sprite_line_renderer_pkg::*;
(
  input  logic        VCLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [7:0]  VLINE,
  input  logic        BANK,
  output logic [7:0]  SADR,
  input  logic [7:0]  SDAT,
  output logic        ROM_REQ,
  output logic [13:0] ROM_ADR,
  input  logic        ROM_ACK,
  input  logic [31:0] ROM_DAT,
  output logic        WEN,
  output logic [9:0]  WAD,
  output logic [3:0]  WDT,
  output logic        BUSY
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSPR - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       vline_l;
  logic             bank_l;
  logic [8:0]       code;
  logic [8:0]       xpos;
  logic             flipx;
  logic             flipy;
  logic [3:0]       row;
  logic             h;
  logic [2:0]       k;

  logic [7:0]       row_raw;
  logic [3:0]       row_eff;
  logic             hit;
  logic [8:0]       col_x;
  logic [3:0]       pixel;
  logic             opaque;
  logic             load;

  // In CHK the RAM is presenting byte 3 (Y), so it is used straight from SDAT.
  always_comb begin
    row_raw = vline_l - SDAT;
    hit     = (SDAT != 8'd0) && (row_raw < 8'(SPH));
    row_eff = flipy ? ~row_raw[3:0] : row_raw[3:0];
    col_x   = xpos + {5'd0, h, k};
    load    = (state == S_FETCH) && ROM_ACK;
  end

  sprite_pixel_shifter u_shifter (
    .clk    (VCLK),
    .rst_n  (RESET_N),
    .load   (load),
    .word   (ROM_DAT),
    .flip   (flipx),
    .sel    (k),
    .pixel  (pixel),
    .opaque (opaque)
  );

  always_ff @(posedge VCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      idx     <= '0;
      vline_l <= '0;
      bank_l  <= 1'b0;
      code    <= '0;
      xpos    <= '0;
      flipx   <= 1'b0;
      flipy   <= 1'b0;
      row     <= '0;
      h       <= 1'b0;
      k       <= '0;
      SADR    <= '0;
      ROM_REQ <= 1'b0;
      ROM_ADR <= '0;
      WEN     <= 1'b0;
      WAD     <= '0;
      WDT     <= '0;
      BUSY    <= 1'b0;
    end else begin
      WEN <= 1'b0;
      if (START) begin
        // Also the abort path: any in-flight fetch is dropped and ignored.
        vline_l <= VLINE;
        bank_l  <= BANK;
        idx     <= '0;
        SADR    <= '0;
        ROM_REQ <= 1'b0;
        BUSY    <= 1'b1;
        state   <= S_RD0;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_RD0: begin
            SADR  <= SADR + 8'd1;
            state <= S_RD1;
          end
          S_RD1: begin
            code[7:0] <= SDAT;
            SADR      <= SADR + 8'd1;
            state     <= S_RD2;
          end
          S_RD2: begin
            xpos[8] <= SDAT[B1_X8];
            code[8] <= SDAT[B1_CODE8];
            flipy   <= SDAT[B1_FLIPY];
            flipx   <= SDAT[B1_FLIPX];
            SADR    <= SADR + 8'd1;
            state   <= S_RD3;
          end
          S_RD3: begin
            xpos[7:0] <= SDAT;
            state     <= S_CHK;
          end
          S_CHK: begin
            if (hit) begin
              row     <= row_eff;
              h       <= 1'b0;
              ROM_REQ <= 1'b1;
              ROM_ADR <= rom_addr(code, row_eff, flipx);
              state   <= S_FETCH;
            end else begin
              state <= S_NEXT;
            end
          end
          S_FETCH: begin
            if (ROM_ACK) begin
              ROM_REQ <= 1'b0;
              k       <= '0;
              state   <= S_DRAW;
            end
          end
          S_DRAW: begin
            WEN <= opaque;
            if (opaque) begin
              WAD <= {bank_l, col_x};
              WDT <= pixel;
            end
            k <= k + 3'd1;
            if (k == 3'd7) begin
              if (!h) begin
                h       <= 1'b1;
                ROM_REQ <= 1'b1;
                ROM_ADR <= rom_addr(code, row, ~flipx);
                state   <= S_FETCH;
              end else begin
                state <= S_NEXT;
              end
            end
          end
          S_NEXT: begin
            if (idx == IDX_LAST) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              SADR  <= {idx + 6'd1, 2'b00};
              state <= S_RD0;
            end
          end
          S_DONE: begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer: attribute RAM and sprite ROM models,
// write/fetch monitors, hand-computed expected write and fetch sequences.
module tb_sprite_line_renderer;

  logic        VCLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [7:0]  VLINE;
  logic        BANK;
  logic [7:0]  SADR;
  logic [7:0]  SDAT;
  logic        ROM_REQ;
  logic [13:0] ROM_ADR;
  logic        ROM_ACK;
  logic [31:0] ROM_DAT;
  logic        WEN;
  logic [9:0]  WAD;
  logic [3:0]  WDT;
  logic        BUSY;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  attr [0:191];
  logic        ack_r = 1'b0;
  logic        late_ack = 1'b0;
  logic        rand_dly = 1'b0;
  int          dly = 0;
  int          cnt = 0;
  logic [13:0] wq[$], rq[$], ew[$], er[$];

  assign ROM_ACK = ack_r | late_ack;

  always #5 VCLK = ~VCLK;

  sprite_line_renderer dut (
    .VCLK    (VCLK),
    .RESET_N (RESET_N),
    .START   (START),
    .VLINE   (VLINE),
    .BANK    (BANK),
    .SADR    (SADR),
    .SDAT    (SDAT),
    .ROM_REQ (ROM_REQ),
    .ROM_ADR (ROM_ADR),
    .ROM_ACK (ROM_ACK),
    .ROM_DAT (ROM_DAT),
    .WEN     (WEN),
    .WAD     (WAD),
    .WDT     (WDT),
    .BUSY    (BUSY)
  );

  // Codes with bit 8 set hold a uniform pixel value equal to code[3:0].
  function automatic logic [31:0] rom_word(input logic [13:0] a);
    if (a[13]) return {8{a[8:5]}};
    return 32'h87654321;
  endfunction

  always @(posedge VCLK) SDAT <= attr[SADR];

  always @(posedge VCLK) begin
    if (!ROM_REQ || ack_r) begin
      ack_r <= 1'b0;
      cnt   <= 0;
    end else if (cnt >= dly) begin
      ack_r   <= 1'b1;
      ROM_DAT <= rom_word(ROM_ADR);
      cnt     <= 0;
      if (rand_dly) dly <= $urandom_range(0, 20);
    end else begin
      cnt <= cnt + 1;
    end
  end

  always @(negedge VCLK) begin
    if (WEN) wq.push_back({WAD, WDT});
    if (ROM_REQ && ROM_ACK) rq.push_back(ROM_ADR);
  end

  task automatic clear_attr();
    for (int i = 0; i < 192; i++) attr[i] = 8'h00;
  endtask

  task automatic set_sprite(input int i, input logic [8:0] code, input logic [8:0] x,
                            input logic [7:0] y, input logic fx, input logic fy);
    attr[i*4]   = code[7:0];
    attr[i*4+1] = {x[8], code[8], fy, fx, 4'b0000};
    attr[i*4+2] = x[7:0];
    attr[i*4+3] = y;
  endtask

  task automatic start_line(input logic [7:0] v, input logic b);
    wq.delete(); rq.delete(); ew.delete(); er.delete();
    @(negedge VCLK);
    VLINE = v; BANK = b; START = 1'b1;
    @(negedge VCLK);
    START = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000 && BUSY; i++) @(negedge VCLK);
    vectors++;
    if (BUSY) begin
      miscompares++;
      $display("FAIL line_timeout BUSY got %b want 0", BUSY);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge VCLK);
      START = ~START;
      VLINE = 8'h45;
      vectors++;
      if ({BUSY, WEN, ROM_REQ, SADR} !== 11'd0) begin
        miscompares++;
        $display("FAIL reset_outputs BUSY/WEN/REQ/SADR got %b want 0", {BUSY, WEN, ROM_REQ, SADR});
      end
    end
    @(negedge VCLK);
    START = 1'b0;
    RESET_N = 1'b1;
    @(negedge VCLK);
    vectors++;
    if (BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release BUSY got %b want 0", BUSY);
    end
  endtask

  task automatic test_basic();
    clear_attr();
    set_sprite(0, 9'h005, 9'h020, 8'h40, 1'b0, 1'b0);
    start_line(8'h45, 1'b1);
    wait_idle();
    er = '{14'h00AA, 14'h00AB};
    for (int c = 0; c < 16; c++) ew.push_back({1'b1, 9'(32'h020 + c), 4'(c % 8 + 1)});
    vectors++;
    if (rq.size() != er.size()) begin
      miscompares++; $display("FAIL basic_fetches got %0d want %0d", rq.size(), er.size());
    end else for (int i = 0; i < er.size(); i++) begin
      vectors++;
      if (rq[i] !== er[i]) begin miscompares++; $display("FAIL basic_rom_adr[%0d] got %h want %h", i, rq[i], er[i]); end
    end
    vectors++;
    if (wq.size() != ew.size()) begin
      miscompares++; $display("FAIL basic_writes got %0d want %0d", wq.size(), ew.size());
    end else for (int i = 0; i < ew.size(); i++) begin
      vectors++;
      if (wq[i] !== ew[i]) begin miscompares++; $display("FAIL basic_wad_wdt[%0d] got %h want %h", i, wq[i], ew[i]); end
    end
  endtask

  task automatic test_flip();
    clear_attr();
    set_sprite(0, 9'h005, 9'h020, 8'h40, 1'b1, 1'b1);
    set_sprite(1, 9'h100, 9'h100, 8'h40, 1'b0, 1'b0);
    start_line(8'h45, 1'b1);
    vectors++;
    if (BUSY !== 1'b1 || SADR !== 8'h00) begin
      miscompares++; $display("FAIL start_busy_sadr got %b/%h want 1/00", BUSY, SADR);
    end
    wait_idle();
    er = '{14'h00B5, 14'h00B4, 14'h200A, 14'h200B};
    for (int c = 0; c < 16; c++) ew.push_back({1'b1, 9'(32'h020 + c), 4'(8 - c % 8)});
    vectors++;
    if (rq.size() != er.size()) begin
      miscompares++; $display("FAIL flip_fetches got %0d want %0d", rq.size(), er.size());
    end else for (int i = 0; i < er.size(); i++) begin
      vectors++;
      if (rq[i] !== er[i]) begin miscompares++; $display("FAIL flip_rom_adr[%0d] got %h want %h", i, rq[i], er[i]); end
    end
    vectors++;
    if (wq.size() != ew.size()) begin
      miscompares++; $display("FAIL flip_writes got %0d want %0d", wq.size(), ew.size());
    end else for (int i = 0; i < ew.size(); i++) begin
      vectors++;
      if (wq[i] !== ew[i]) begin miscompares++; $display("FAIL flip_wad_wdt[%0d] got %h want %h", i, wq[i], ew[i]); end
    end
  endtask

  task automatic test_wrap();
    clear_attr();
    set_sprite(0, 9'h005, 9'h1F8, 8'h01, 1'b0, 1'b0);
    set_sprite(2, 9'h005, 9'h080, 8'h00, 1'b0, 1'b0);
    set_sprite(5, 9'h005, 9'h080, 8'hF5, 1'b0, 1'b0);
    set_sprite(6, 9'h103, 9'h100, 8'hF6, 1'b0, 1'b0);
    start_line(8'h05, 1'b0);
    wait_idle();
    er = '{14'h00A8, 14'h00A9, 14'h207E, 14'h207F};
    for (int c = 0; c < 16; c++) ew.push_back({1'b0, 9'(32'h1F8 + c), 4'(c % 8 + 1)});
    for (int c = 0; c < 16; c++) ew.push_back({1'b0, 9'(32'h100 + c), 4'd3});
    vectors++;
    if (rq.size() != er.size()) begin
      miscompares++; $display("FAIL wrap_fetches got %0d want %0d", rq.size(), er.size());
    end else for (int i = 0; i < er.size(); i++) begin
      vectors++;
      if (rq[i] !== er[i]) begin miscompares++; $display("FAIL wrap_rom_adr[%0d] got %h want %h", i, rq[i], er[i]); end
    end
    vectors++;
    if (wq.size() != ew.size()) begin
      miscompares++; $display("FAIL wrap_writes got %0d want %0d", wq.size(), ew.size());
    end else for (int i = 0; i < ew.size(); i++) begin
      vectors++;
      if (wq[i] !== ew[i]) begin miscompares++; $display("FAIL wrap_wad_wdt[%0d] got %h want %h", i, wq[i], ew[i]); end
    end
  endtask

  task automatic test_overlap();
    clear_attr();
    set_sprite(3, 9'h103, 9'h050, 8'h40, 1'b0, 1'b0);
    set_sprite(7, 9'h107, 9'h058, 8'h40, 1'b0, 1'b0);
    start_line(8'h40, 1'b0);
    wait_idle();
    er = '{14'h2060, 14'h2061, 14'h20E0, 14'h20E1};
    for (int c = 0; c < 16; c++) ew.push_back({1'b0, 9'(32'h050 + c), 4'd3});
    for (int c = 0; c < 16; c++) ew.push_back({1'b0, 9'(32'h058 + c), 4'd7});
    vectors++;
    if (rq.size() != er.size()) begin
      miscompares++; $display("FAIL overlap_fetches got %0d want %0d", rq.size(), er.size());
    end else for (int i = 0; i < er.size(); i++) begin
      vectors++;
      if (rq[i] !== er[i]) begin miscompares++; $display("FAIL overlap_rom_adr[%0d] got %h want %h", i, rq[i], er[i]); end
    end
    vectors++;
    if (wq.size() != ew.size()) begin
      miscompares++; $display("FAIL overlap_writes got %0d want %0d", wq.size(), ew.size());
    end else for (int i = 0; i < ew.size(); i++) begin
      vectors++;
      if (wq[i] !== ew[i]) begin miscompares++; $display("FAIL overlap_wad_wdt[%0d] got %h want %h", i, wq[i], ew[i]); end
    end
  endtask

  task automatic test_abort();
    clear_attr();
    set_sprite(10, 9'h005, 9'h020, 8'h40, 1'b0, 1'b0);
    start_line(8'h45, 1'b1);
    for (int i = 0; i < 2000 && !WEN; i++) @(negedge VCLK);
    vectors++;
    if (WEN !== 1'b1) begin miscompares++; $display("FAIL abort_draw_wait WEN got %b want 1", WEN); end
    repeat (3) @(negedge VCLK);
    BANK = 1'b0; START = 1'b1;
    @(negedge VCLK);
    START = 1'b0;
    vectors++;
    if ({WEN, ROM_REQ, SADR, BUSY} !== 11'b0_0_00000000_1) begin
      miscompares++;
      $display("FAIL abort_outputs WEN/REQ/SADR/BUSY got %b/%b/%h/%b want 0/0/00/1", WEN, ROM_REQ, SADR, BUSY);
    end
    wq.delete(); rq.delete();
    late_ack = 1'b1;
    @(negedge VCLK);
    late_ack = 1'b0;
    wait_idle();
    er = '{14'h00AA, 14'h00AB};
    for (int c = 0; c < 16; c++) ew.push_back({1'b0, 9'(32'h020 + c), 4'(c % 8 + 1)});
    vectors++;
    if (rq.size() != er.size()) begin
      miscompares++; $display("FAIL abort_fetches got %0d want %0d", rq.size(), er.size());
    end else for (int i = 0; i < er.size(); i++) begin
      vectors++;
      if (rq[i] !== er[i]) begin miscompares++; $display("FAIL abort_rom_adr[%0d] got %h want %h", i, rq[i], er[i]); end
    end
    vectors++;
    if (wq.size() != ew.size()) begin
      miscompares++; $display("FAIL abort_writes got %0d want %0d", wq.size(), ew.size());
    end else for (int i = 0; i < ew.size(); i++) begin
      vectors++;
      if (wq[i] !== ew[i]) begin miscompares++; $display("FAIL abort_wad_wdt[%0d] got %h want %h", i, wq[i], ew[i]); end
    end
  endtask

  task automatic test_random_stall();
    rand_dly = 1'b1;
    clear_attr();
    set_sprite(0, 9'h005, 9'h020, 8'h40, 1'b0, 1'b0);
    set_sprite(10, 9'h103, 9'h030, 8'h3F, 1'b1, 1'b0);
    start_line(8'h45, 1'b1);
    wait_idle();
    rand_dly = 1'b0;
    er = '{14'h00AA, 14'h00AB, 14'h206D, 14'h206C};
    for (int c = 0; c < 16; c++) ew.push_back({1'b1, 9'(32'h020 + c), 4'(c % 8 + 1)});
    for (int c = 0; c < 16; c++) ew.push_back({1'b1, 9'(32'h030 + c), 4'd3});
    vectors++;
    if (rq.size() != er.size()) begin
      miscompares++; $display("FAIL stall_fetches got %0d want %0d", rq.size(), er.size());
    end else for (int i = 0; i < er.size(); i++) begin
      vectors++;
      if (rq[i] !== er[i]) begin miscompares++; $display("FAIL stall_rom_adr[%0d] got %h want %h", i, rq[i], er[i]); end
    end
    vectors++;
    if (wq.size() != ew.size()) begin
      miscompares++; $display("FAIL stall_writes got %0d want %0d", wq.size(), ew.size());
    end else for (int i = 0; i < ew.size(); i++) begin
      vectors++;
      if (wq[i] !== ew[i]) begin miscompares++; $display("FAIL stall_wad_wdt[%0d] got %h want %h", i, wq[i], ew[i]); end
    end
  endtask

  task automatic test_midline_reset();
    clear_attr();
    set_sprite(4, 9'h005, 9'h020, 8'h40, 1'b0, 1'b0);
    start_line(8'h45, 1'b1);
    for (int i = 0; i < 2000 && !WEN; i++) @(negedge VCLK);
    RESET_N = 1'b0;
    #1;
    vectors++;
    if ({BUSY, WEN, ROM_REQ} !== 3'b000) begin
      miscompares++; $display("FAIL midline_reset BUSY/WEN/REQ got %b want 000", {BUSY, WEN, ROM_REQ});
    end
    wq.delete();
    repeat (2) @(negedge VCLK);
    RESET_N = 1'b1;
    repeat (40) @(negedge VCLK);
    vectors++;
    if (wq.size() != 0 || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_quiet writes/BUSY got %0d/%b want 0/0", wq.size(), BUSY);
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    VLINE   = 8'h00;
    BANK    = 1'b0;
    clear_attr();
    test_reset();
    test_basic();
    test_flip();
    test_wrap();
    test_overlap();
    test_abort();
    test_random_stall();
    test_midline_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
